// File: rtl/psum_mem_acc.sv
// psum_mem_acc: NUM_CH-lane partial-sum store with overwrite/accumulate writes, registered
// reads with write-first bypass and a bulk-clear sequencer. Define PMEM_SAT_EN for saturating accumulate.
module psum_mem_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr,
    output logic                         o_busy,
    input  logic [NUM_CH-1:0]            i_wr_en,
    input  logic                         i_acc_en,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_wr_data,
    input  logic [NUM_CH-1:0]            i_rd_en,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_CH-1:0]            o_rd_valid
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int SW    = DATA_WIDTH + $clog2(NUM_CH+1);
`ifdef PMEM_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef logic [NUM_CH-1:0][ADDR_WIDTH-1:0] addr_vec_t;
    typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_vec_t;
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [NUM_CH-1:0]     r_st_vld;
    logic                  r_st_acc;
    addr_vec_t             r_st_addr;
    data_vec_t             r_st_data;
    logic [NUM_CH-1:0]     r_rd_valid;
    data_vec_t             r_rd_data;

    addr_vec_t             w_rd_addr;
    data_vec_t             w_cm_val;
    data_vec_t             w_rd_val;
    logic                  w_clr_go;
    logic                  w_rd_ok;

    assign w_rd_addr  = i_rd_addr;
    assign w_clr_go   = i_clr && (r_state == S_IDLE);
    // reads are refused from the clear-start cycle onward so valid never rises with busy
    assign w_rd_ok    = !r_busy && !w_clr_go;
    assign o_busy     = r_busy;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

    // Value address a holds once the staged write commits; old when the stage misses a.
    function automatic logic [DATA_WIDTH-1:0] f_resolve(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] old,
        input logic [NUM_CH-1:0]     vld,
        input logic                  acc,
        input addr_vec_t             addr,
        input data_vec_t             data
    );
        logic signed [SW-1:0]  sum;
        logic [DATA_WIDTH-1:0] res;
        sum = {{(SW-DATA_WIDTH){old[DATA_WIDTH-1]}}, old};
        res = old;
        for (int j = 0; j < NUM_CH; j++) begin
            if (vld[j] && addr[j] == a) begin
                sum = sum + {{(SW-DATA_WIDTH){data[j][DATA_WIDTH-1]}}, data[j]};
                res = data[j];
            end
        end
        if (acc) begin
`ifdef PMEM_SAT_EN
            if (sum > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
            else if (sum < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
            else                    res = sum[DATA_WIDTH-1:0];
`else
            res = sum[DATA_WIDTH-1:0];
`endif
        end
        return res;
    endfunction

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign w_cm_val[k] = f_resolve(r_st_addr[k], r_mem[r_st_addr[k]],
                                       r_st_vld, r_st_acc, r_st_addr, r_st_data);
        assign w_rd_val[k] = f_resolve(w_rd_addr[k], r_mem[w_rd_addr[k]],
                                       r_st_vld, r_st_acc, r_st_addr, r_st_data);
    end

    // Colliding lanes all write the same resolved value; the clear zero is last so it prevails.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            for (int k = 0; k < NUM_CH; k++)
                if (r_st_vld[k]) r_mem[r_st_addr[k]] <= w_cm_val[k];
            if (r_state == S_CLEAR) r_mem[r_cnt] <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_clr) begin
                    r_state <= S_CLEAR;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                end
                S_CLEAR: if (&r_cnt) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_st_vld   <= '0;
            r_st_acc   <= 1'b0;
            r_st_addr  <= '0;
            r_st_data  <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_st_vld   <= r_busy ? '0 : i_wr_en;
            r_st_acc   <= i_acc_en;
            r_st_addr  <= i_wr_addr;
            r_st_data  <= i_wr_data;
            r_rd_valid <= i_rd_en & {NUM_CH{w_rd_ok}};
            for (int k = 0; k < NUM_CH; k++)
                if (i_rd_en[k] && w_rd_ok) r_rd_data[k] <= w_rd_val[k];
        end
    end

endmodule

// File: tb/tb_psum_mem_acc.sv
// Bench for psum_mem_acc: directed scenarios plus random traffic against an array-based model.
module tb_psum_mem_acc;
    localparam int DW = 16, AW = 8, NC = 4, DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             busy;
    logic [NC-1:0]    wr_en = '0;
    logic             acc = 1'b0;
    logic [NC*AW-1:0] wr_addr = '0;
    logic [NC*DW-1:0] wr_data = '0;
    logic [NC-1:0]    rd_en = '0;
    logic [NC*AW-1:0] rd_addr = '0;
    logic [NC*DW-1:0] rd_data;
    logic [NC-1:0]    rd_valid;

    always #5 clk = ~clk;

    psum_mem_acc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_busy(busy),
        .i_wr_en(wr_en), .i_acc_en(acc), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state: memory as signed ints, pending stage, expected outputs
    int m_mem [DEPTH];
    bit m_busy;
    int m_cnt;
    bit p_vld [NC];
    bit p_acc;
    int p_addr [NC];
    int p_data [NC];
    bit e_vld [NC];
    int e_data [NC];

    function automatic int sx16(input logic [15:0] x);
        logic signed [15:0] t;
        t = x;
        return int'(t);
    endfunction

    function automatic int narrow(input int v);
`ifdef PMEM_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        return sx16(v[15:0]);
`endif
    endfunction

    function automatic void model_edge();
        bit was_busy;
        int s [int];
        was_busy = m_busy;
        if (!rst_n) begin
            m_busy = 0; m_cnt = 0;
            for (int k = 0; k < NC; k++) begin
                p_vld[k] = 0; e_vld[k] = 0; e_data[k] = 0;
            end
            return;
        end
        if (p_acc) begin
            for (int k = 0; k < NC; k++)
                if (p_vld[k]) begin
                    if (!s.exists(p_addr[k])) s[p_addr[k]] = m_mem[p_addr[k]];
                    s[p_addr[k]] += p_data[k];
                end
            foreach (s[a]) m_mem[a] = narrow(s[a]);
        end else begin
            for (int k = 0; k < NC; k++)
                if (p_vld[k]) m_mem[p_addr[k]] = p_data[k];
        end
        for (int k = 0; k < NC; k++) begin
            e_vld[k] = 0;
            if (!was_busy && !clr && rd_en[k]) begin
                e_vld[k] = 1;
                e_data[k] = m_mem[int'(rd_addr[k*AW +: AW])];
            end
        end
        if (was_busy) begin
            m_mem[m_cnt] = 0;
            m_cnt++;
            if (m_cnt == DEPTH) begin m_busy = 0; m_cnt = 0; end
        end
        p_acc = acc;
        for (int k = 0; k < NC; k++) begin
            p_vld[k]  = !was_busy && wr_en[k];
            p_addr[k] = int'(wr_addr[k*AW +: AW]);
            p_data[k] = sx16(wr_data[k*DW +: DW]);
        end
        if (!was_busy && clr) begin m_busy = 1; m_cnt = 0; end
    endfunction

    task automatic step();
        logic [15:0] ed;
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", busy, m_busy);
        for (int k = 0; k < NC; k++) begin
            ed = e_data[k][15:0];
            chk($sformatf("rd_valid[%0d]", k), rd_valid[k], e_vld[k]);
            chk($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], ed);
        end
    endtask

    task automatic idle();
        wr_en = '0; rd_en = '0; acc = 1'b0; clr = 1'b0;
    endtask

    task automatic wr(input int k, input int a, input int d);
        wr_en[k] = 1'b1;
        wr_addr[k*AW +: AW] = AW'(a);
        wr_data[k*DW +: DW] = DW'(d);
    endtask

    task automatic rd(input int k, input int a);
        rd_en[k] = 1'b1;
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        int n;
        // reset then full clear
        idle(); rst_n = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", rd_valid, 0);
        rst_n = 1'b1;
        clr = 1'b1; step(); clr = 1'b0;
        n = 0;
        while (busy && n < 300) begin step(); n++; end
        chk("clr_len", n, 256);
        rd(0, 0); rd(1, 17); rd(2, 128); rd(3, 255); step();
        for (int k = 0; k < NC; k++) begin
            chk("t1_valid", rd_valid[k], 1);
            chk("t1_data", rd_data[k*DW +: DW], 0);
        end

        // overwrite then three accumulates
        idle(); wr(0, 5, 100); step();
        for (int i = 0; i < 3; i++) begin idle(); acc = 1'b1; wr(0, 5, 7); step(); end
        idle(); step();
        rd(0, 5); step();
        chk("t2_acc", rd_data[15:0], 121);

        // four lanes same address
        idle(); for (int k = 0; k < NC; k++) wr(k, 9, k + 1); step();
        idle(); rd(0, 9); step();
        chk("t3_ovw", rd_data[15:0], 4);
        idle(); wr(0, 9, 0); step();
        idle(); acc = 1'b1; for (int k = 0; k < NC; k++) wr(k, 9, k + 1); step();
        idle(); rd(0, 9); step();
        chk("t3_acc", rd_data[15:0], 10);

        // bypass timing
        idle(); wr(0, 3, 50); step();
        idle(); step();
        idle(); acc = 1'b1; wr(0, 3, 1); rd(1, 3); step();
        chk("t4_old", rd_data[DW +: DW], 50);
        idle(); rd(1, 3); step();
        chk("t4_byp", rd_data[DW +: DW], 51);

        // overflow at the positive rail
        idle(); wr(0, 20, 32767); step();
        idle(); acc = 1'b1; wr(0, 20, 1); step();
        idle(); step();
        rd(2, 20); step();
`ifdef PMEM_SAT_EN
        chk("t5_ovf", rd_data[2*DW +: DW], 32'h7fff);
`else
        chk("t5_ovf", rd_data[2*DW +: DW], 32'h8000);
`endif

        // reset in the middle of a clear
        idle(); wr(0, 100, 1234); step();
        idle(); step();
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 1; i < 40; i++) begin
            idle(); wr(1, 100, 999); rd(2, 100); step();
        end
        idle(); rst_n = 1'b0; step();
        chk("t6_busy", busy, 0);
        rst_n = 1'b1; rd(0, 100); rd(1, 0); step();
        chk("t6_keep", rd_data[15:0], 1234);
        chk("t6_clr0", rd_data[DW +: DW], 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst_n = ($urandom_range(0, 499) != 0);
            clr   = ($urandom_range(0, 399) == 0);
            acc   = $urandom_range(0, 1);
            for (int k = 0; k < NC; k++) begin
                if ($urandom_range(0, 1) == 1)
                    wr(k, rnd_addr(), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                                               : int'($urandom_range(0, 15)));
                if ($urandom_range(0, 1) == 1) rd(k, rnd_addr());
            end
            step();
        end
        idle(); rst_n = 1'b1; step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
